// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Sized for a 32-bit RISC-V fetch path.
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:2] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ring.sv
// Ring of fetch entries with alloc/fill/read pointers.
// Pointers carry an extra wrap bit so full and empty are distinct.
module if_fetch_ring
    import if_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output logic [PTRW:0]   used_o,
    output logic [PTRW:0]   pending_o,
    output logic            head_filled_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [XLEN-1:0] head_pc_o
);

    fetch_entry_t mem_q [DEPTH];

    logic [PTRW:0] alloc_q, alloc_d;
    logic [PTRW:0] fill_q, fill_d;
    logic [PTRW:0] rd_q, rd_d;

    logic [PTRW-1:0] a_idx, f_idx, r_idx;
    fetch_entry_t    head;

    assign a_idx = alloc_q[PTRW-1:0];
    assign f_idx = fill_q[PTRW-1:0];
    assign r_idx = rd_q[PTRW-1:0];

    assign used_o    = alloc_q - rd_q;
    assign pending_o = alloc_q - fill_q;

    assign head          = mem_q[r_idx];
    assign head_filled_o = head.filled;
    assign head_instr_o  = head.instr;
    assign head_pc_o     = {head.pc, 2'b00};

    always_comb begin
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        if (clear_i) begin
            alloc_d = '0;
            fill_d  = '0;
            rd_d    = '0;
        end else begin
            if (alloc_i) alloc_d = alloc_q + 1'b1;
            if (fill_i)  fill_d  = fill_q + 1'b1;
            if (pop_i)   rd_d    = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q <= '0;
            fill_q  <= '0;
            rd_q    <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
        end
    end

    // Alloc and fill never target the same slot: that needs pending == 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
            end
        end else if (!clear_i) begin
            if (alloc_i) begin
                mem_q[a_idx].pc     <= alloc_pc_i[XLEN-1:2];
                mem_q[a_idx].filled <= 1'b0;
            end
            if (fill_i) begin
                mem_q[f_idx].instr  <= fill_instr_i;
                mem_q[f_idx].filled <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch queue between the PC stage, the ICache and Decode.
// Pairs in-order ICache responses with their PCs; drops stale ones after a flush.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic [31:0] iPCADDR,
    output logic        oStallI,
    input  logic        iFlush,
    output logic        oICReq,
    output logic [31:0] oICAddr,
    input  logic        iICGnt,
    input  logic        iICRvalid,
    input  logic [31:0] iICRdata,
    output logic        oValid,
    output logic [31:0] oInstr,
    output logic [31:0] oInstrPC,
    input  logic        iIDReady
);

    localparam int DW = PTRW + 2;

    logic [PTRW:0] used, pending;
    logic [DW-1:0] disc_q, disc_d, disc_sum;
    logic          full, alloc, fill, pop;
    logic          head_filled;

    // used never exceeds DEPTH, so its top bit alone marks full.
    assign full    = used[PTRW];
    assign oICReq  = iRSTn & ~full & ~iFlush;
    assign alloc   = oICReq & iICGnt;
    assign oStallI = ~iRSTn | (~alloc & ~iFlush);
    assign oICAddr = {iPCADDR[31:2], 2'b00};

    assign oValid = iRSTn & ~iFlush & head_filled & (used != '0);
    assign pop    = oValid & iIDReady;
    assign fill   = iICRvalid & ~iFlush & (disc_q == '0)
                  & (pending != '0);

    always_comb begin
        disc_sum = disc_q + DW'(pending);
        disc_d   = disc_q;
        if (iFlush) begin
            disc_d = disc_sum;
            if (iICRvalid && disc_sum != '0) disc_d = disc_sum - 1'b1;
        end else if (iICRvalid && disc_q != '0) begin
            disc_d = disc_q - 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) disc_q <= '0;
        else        disc_q <= disc_d;
    end

    if_fetch_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_i         (iCLK),
        .rst_ni        (iRSTn),
        .clear_i       (iFlush),
        .alloc_i       (alloc),
        .alloc_pc_i    (oICAddr),
        .fill_i        (fill),
        .fill_instr_i  (iICRdata),
        .pop_i         (pop),
        .used_o        (used),
        .pending_o     (pending),
        .head_filled_o (head_filled),
        .head_instr_o  (oInstr),
        .head_pc_o     (oInstrPC)
    );

    a_no_orphan_rsp: assert property (
        @(posedge iCLK) disable iff (!iRSTn)
        !(iICRvalid && pending == '0 && disc_q == '0)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model.
// Includes a PC-stage model and an in-order ICache model with random latency.
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam int D = 4;

    logic        iCLK = 1'b0;
    logic        iRSTn = 1'b0;
    logic [31:0] iPCADDR = '0;
    logic        oStallI;
    logic        iFlush = 1'b0;
    logic        oICReq;
    logic [31:0] oICAddr;
    logic        iICGnt = 1'b0;
    logic        iICRvalid = 1'b0;
    logic [31:0] iICRdata = '0;
    logic        oValid;
    logic [31:0] oInstr;
    logic [31:0] oInstrPC;
    logic        iIDReady = 1'b0;

    if_fetch_queue #(.DEPTH(D)) dut (
        .iCLK      (iCLK),
        .iRSTn     (iRSTn),
        .iPCADDR   (iPCADDR),
        .oStallI   (oStallI),
        .iFlush    (iFlush),
        .oICReq    (oICReq),
        .oICAddr   (oICAddr),
        .iICGnt    (iICGnt),
        .iICRvalid (iICRvalid),
        .iICRdata  (iICRdata),
        .oValid    (oValid),
        .oInstr    (oInstr),
        .oInstrPC  (oInstrPC),
        .iIDReady  (iIDReady)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          have;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        longint      due;
    } rsp_t;

    ent_t        mq[$];
    rsp_t        icq[$];
    int          disc = 0;
    longint      cyc = 0;
    logic [31:0] pc = '0;

    int p_gnt = 100, p_rdy = 100, p_flush = 0;
    int lat_min = 1, lat_max = 1;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic cycle(input bit force_flush);
        logic erq, est, ev, acc, pop, rv;
        logic [31:0] tgt, req_addr;
        int pend;
        @(negedge iCLK);
        iFlush    = force_flush || ($urandom_range(99) < p_flush);
        iICGnt    = ($urandom_range(99) < p_gnt);
        iIDReady  = ($urandom_range(99) < p_rdy);
        iICRvalid = (icq.size() > 0) && (icq[0].due <= cyc);
        iICRdata  = iICRvalid ? imem(icq[0].addr) : $urandom;
        iPCADDR   = pc | 32'($urandom_range(3));
        #1;
        erq = (mq.size() < D) && !iFlush;
        est = !(erq && iICGnt) && !iFlush;
        ev  = !iFlush && (mq.size() > 0) && mq[0].have;
        req_addr = {pc[31:2], 2'b00};
        check("req", 32'(oICReq), 32'(erq));
        check("stall", 32'(oStallI), 32'(est));
        check("valid", 32'(oValid), 32'(ev));
        check("icaddr", oICAddr, req_addr);
        if (ev) begin
            check("instr_pc", oInstrPC, mq[0].pc);
            check("instr", oInstr, imem(mq[0].pc));
        end
        acc = erq && iICGnt;
        pop = ev && iIDReady;
        rv  = iICRvalid;
        @(posedge iCLK);
        if (rv) void'(icq.pop_front());
        if (acc) icq.push_back('{addr: req_addr,
                                 due: cyc + longint'($urandom_range(lat_max, lat_min))});
        if (iFlush) begin
            pend = 0;
            foreach (mq[i]) if (!mq[i].have) pend++;
            disc = disc + pend - (rv ? 1 : 0);
            if (disc < 0) disc = 0;
            mq.delete();
            tgt = 32'h100 + (32'($urandom_range(1023)) << 2);
            pc = tgt;
        end else begin
            if (rv) begin
                if (disc > 0) disc--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].have) begin
                            mq[i].have = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{pc: req_addr, have: 1'b0});
            if (!est) pc = pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic apply_reset();
        logic ev;
        iFlush   = 1'b0;
        iIDReady = 1'b0;
        iICGnt   = 1'b0;
        @(negedge iCLK);
        #1;
        ev = (mq.size() > 0) && mq[0].have;
        check("pre_rst_valid", 32'(oValid), 32'(ev));
        iRSTn = 1'b0;
        #1;
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_req", 32'(oICReq), 32'd0);
        check("rst_stall", 32'(oStallI), 32'd1);
        check("rst_instr", oInstr, NOP_INSTR);
        check("rst_instr_pc", oInstrPC, 32'd0);
        mq.delete();
        icq.delete();
        disc = 0;
        pc = '0;
        iICRvalid = 1'b0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRSTn = 1'b1;
    endtask

    task automatic set_knobs(input int g, input int r, input int f,
                             input int lmin, input int lmax);
        p_gnt = g; p_rdy = r; p_flush = f;
        lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        int n;
        apply_reset();

        // Streaming at latency 1, then back-pressure until full and drain.
        set_knobs(100, 100, 0, 1, 1);
        repeat (12) cycle(1'b0);
        set_knobs(100, 0, 0, 1, 1);
        repeat (8) cycle(1'b0);
        set_knobs(100, 100, 0, 1, 1);
        repeat (10) cycle(1'b0);

        // Flush with two requests outstanding at latency 3.
        apply_reset();
        set_knobs(100, 100, 0, 3, 3);
        repeat (2) cycle(1'b0);
        cycle(1'b1);
        repeat (12) cycle(1'b0);

        // Grant withheld for several cycles.
        set_knobs(0, 100, 0, 1, 2);
        repeat (5) cycle(1'b0);
        set_knobs(100, 100, 0, 1, 2);
        repeat (6) cycle(1'b0);

        // Async reset while an instruction is waiting at the head.
        set_knobs(100, 0, 0, 1, 1);
        n = 0;
        while (!(mq.size() > 0 && mq[0].have) && n < 20) begin
            cycle(1'b0);
            n++;
        end
        check("rst_setup", 32'(mq.size() > 0 && mq[0].have), 32'd1);
        apply_reset();
        set_knobs(100, 100, 0, 1, 1);
        repeat (6) cycle(1'b0);

        // Random mixes, including flushes coinciding with responses.
        set_knobs(100, 100, 20, 1, 1);
        repeat (300) cycle(1'b0);
        set_knobs(70, 60, 8, 1, 4);
        repeat (600) cycle(1'b0);
        set_knobs(50, 30, 5, 2, 4);
        repeat (600) cycle(1'b0);
        set_knobs(90, 90, 15, 1, 3);
        repeat (600) cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
